// File: rtl/mantissa_divider_28.sv
// Iterative SIMD restoring divider for normalized mantissas: 1x28, 2x14 or 4x7 lanes.
// Each of four lane slots runs an independent W+1 step radix-2 restoring division.
module mantissa_divider_28 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] A,
  input  logic [27:0] B,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Q,
  output logic [3:0]  sticky,
  output logic [3:0]  dz
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  typedef enum logic [1:0] {Mode1, Mode2, Mode4} mode_e;

  function automatic logic [4:0] lane_w(mode_e m);
    case (m)
      Mode2:   return 5'd14;
      Mode4:   return 5'd7;
      default: return 5'd28;
    endcase
  endfunction

  function automatic logic [3:0] lane_act(mode_e m);
    case (m)
      Mode2:   return 4'b0011;
      Mode4:   return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d, op_mode;
  logic [4:0]  cnt_q, cnt_d;
  logic [29:0] r_q   [4];
  logic [29:0] r_d   [4];
  logic [29:0] b_q   [4];
  logic [29:0] b_d   [4];
  logic [28:0] quo_q [4];
  logic [28:0] quo_d [4];
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] q_out_q, q_out_d;
  logic [3:0]  sticky_q, sticky_d;
  logic [3:0]  dz_q, dz_d;

  logic [29:0] a_lane   [4];
  logic [29:0] b_lane   [4];
  logic [29:0] r_step   [4];
  logic [28:0] quo_step [4];
  logic [28:0] q_final  [4];
  logic [3:0]  sticky_fin, dz_fin;
  logic [31:0] q_packed;

  assign op_mode = (op == 2'b01) ? Mode2 : (op == 2'b10) ? Mode4 : Mode1;

  // Unpack the incoming operands into zero-extended lane slots.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_lane[i] = '0;
      b_lane[i] = '0;
    end
    unique case (op_mode)
      Mode2: begin
        a_lane[0] = {16'b0, A[13:0]};
        a_lane[1] = {16'b0, A[27:14]};
        b_lane[0] = {16'b0, B[13:0]};
        b_lane[1] = {16'b0, B[27:14]};
      end
      Mode4: begin
        for (int i = 0; i < 4; i++) begin
          a_lane[i] = {23'b0, A[i*7 +: 7]};
          b_lane[i] = {23'b0, B[i*7 +: 7]};
        end
      end
      default: begin
        a_lane[0] = {2'b0, A};
        b_lane[0] = {2'b0, B};
      end
    endcase
  end

  // One restoring step per lane; R stays within W+2 bits so bit 29 never carries.
  always_comb begin
    logic [29:0] r_sub;
    logic        ge;
    for (int i = 0; i < 4; i++) begin
      ge          = (r_q[i] >= b_q[i]);
      r_sub       = ge ? (r_q[i] - b_q[i]) : r_q[i];
      r_step[i]   = {r_sub[28:0], 1'b0};
      quo_step[i] = {quo_q[i][27:0], ge};
    end
  end

  // Final per-lane results and output packing for the last iteration.
  always_comb begin
    logic [4:0]  w;
    logic [3:0]  act;
    logic [28:0] mask;
    w    = lane_w(mode_q);
    act  = lane_act(mode_q);
    mask = ~(29'h1FFFFFFF << (w + 5'd1));
    sticky_fin = '0;
    dz_fin     = '0;
    for (int i = 0; i < 4; i++) begin
      q_final[i] = '0;
      if (act[i]) begin
        dz_fin[i]     = ~b_q[i][w - 5'd1];
        sticky_fin[i] = ~dz_fin[i] & (r_step[i] != '0);
        q_final[i]    = dz_fin[i] ? mask : (quo_step[i] & mask);
      end
    end
    q_packed = '0;
    unique case (mode_q)
      Mode2: begin
        q_packed[14:0]  = q_final[0][14:0];
        q_packed[29:15] = q_final[1][14:0];
      end
      Mode4: begin
        for (int i = 0; i < 4; i++) q_packed[i*8 +: 8] = q_final[i][7:0];
      end
      default: q_packed[28:0] = q_final[0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_out_d     = q_out_q;
    sticky_d    = sticky_q;
    dz_d        = dz_q;
    for (int i = 0; i < 4; i++) begin
      r_d[i]   = r_q[i];
      b_d[i]   = b_q[i];
      quo_d[i] = quo_q[i];
    end
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StCalc;
          in_ready_d = 1'b0;
          mode_d     = op_mode;
          cnt_d      = lane_w(op_mode) + 5'd1;
          for (int i = 0; i < 4; i++) begin
            r_d[i]   = a_lane[i];
            b_d[i]   = b_lane[i];
            quo_d[i] = '0;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 5'd1;
        for (int i = 0; i < 4; i++) begin
          r_d[i]   = r_step[i];
          quo_d[i] = quo_step[i];
        end
        if (cnt_q == 5'd1) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          q_out_d     = q_packed;
          sticky_d    = sticky_fin;
          dz_d        = dz_fin;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= Mode1;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_out_q     <= '0;
      sticky_q    <= '0;
      dz_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        r_q[i]   <= '0;
        b_q[i]   <= '0;
        quo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_out_q     <= q_out_d;
      sticky_q    <= sticky_d;
      dz_q        <= dz_d;
      for (int i = 0; i < 4; i++) begin
        r_q[i]   <= r_d[i];
        b_q[i]   <= b_d[i];
        quo_q[i] <= quo_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_out_q;
  assign sticky    = sticky_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_mantissa_divider_28.sv
// Bench for mantissa_divider_28: fixed vector table, randomized ops against an arithmetic
// model, plus back-pressure and mid-division reset sequences.
module tb_mantissa_divider_28;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] A, B;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Q;
  logic [3:0]  sticky, dz;

  int checks = 0;
  int errors = 0;

  mantissa_divider_28 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .sticky    (sticky),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [27:0] a;
    logic [27:0] b;
    logic [31:0] q;
    logic [3:0]  s;
    logic [3:0]  d;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane-wise real division: floor(A*2^W/B) truncated to W+1 bits, remainder flag, dz flag.
  task automatic model(input logic [1:0] o, input logic [27:0] a, input logic [27:0] b,
                       output logic [31:0] q, output logic [3:0] s, output logic [3:0] d);
    longint unsigned w, n, al, bl, num, qv, acc;
    w   = (o == 2'b01) ? 14 : (o == 2'b10) ? 7 : 28;
    n   = 28 / w;
    acc = 0;
    s   = '0;
    d   = '0;
    for (int l = 0; l < int'(n); l++) begin
      al = (longint'(a) >> (l * w)) & ((64'd1 << w) - 1);
      bl = (longint'(b) >> (l * w)) & ((64'd1 << w) - 1);
      if (((bl >> (w - 1)) & 1) == 0) begin
        d[l] = 1'b1;
        qv   = (64'd1 << (w + 1)) - 1;
      end else begin
        num  = al << w;
        qv   = (num / bl) & ((64'd1 << (w + 1)) - 1);
        s[l] = (num % bl) != 0;
      end
      acc = acc | (qv << (l * (w + 1)));
    end
    q = 32'(acc);
  endtask

  task automatic start_op(input logic [1:0] o, input logic [27:0] a, input logic [27:0] b);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    op = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 28'($urandom);
    B = 28'($urandom);
    op = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    chk("out_valid_after_handshake", 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.op, v.a, v.b);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_Q"}, 64'(Q), 64'(v.q));
    chk({tag, "_sticky"}, 64'(sticky), 64'(v.s));
    chk({tag, "_dz"}, 64'(dz), 64'(v.d));
    release_result();
  endtask

  vec_t vecs[6];

  initial begin
    vec_t v;
    logic [31:0] q_hold;
    int lat;

    vecs[0] = '{2'b00, 28'h8000000, 28'h8000000, 32'h10000000, 4'h0, 4'h0, 29};
    vecs[1] = '{2'b00, 28'hC000000, 28'h8000000, 32'h18000000, 4'h0, 4'h0, 29};
    vecs[2] = '{2'b10, {4{7'h40}}, {4{7'h60}}, 32'h55555555, 4'hF, 4'h0, 8};
    vecs[3] = '{2'b01, {14'h2000, 14'h2000}, {14'h2000, 14'h0000}, 32'h20007FFF,
                4'h0, 4'h1, 15};
    vecs[4] = '{2'b11, 28'h8000000, 28'h8000000, 32'h10000000, 4'h0, 4'h0, 29};
    vecs[5] = '{2'b10, {7'h7F, 7'h40, 7'h7F, 7'h01}, {7'h7F, 7'h7F, 7'h40, 7'h40},
                32'h8040FE02, 4'b0100, 4'h0, 8};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    op = '0;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_Q", 64'(Q), 64'd0);
    chk("reset_sticky_dz", 64'({sticky, dz}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized operands, mostly normalized, occasional unnormalized divisor lanes.
    for (int n = 0; n < 40; n++) begin
      int w;
      logic [27:0] a, b;
      v.op = 2'($urandom);
      w = (v.op == 2'b01) ? 14 : (v.op == 2'b10) ? 7 : 28;
      a = '0;
      b = '0;
      for (int l = 0; l < 28 / w; l++) begin
        logic [27:0] la, lb, msb;
        msb = 28'd1 << (w - 1);
        la = 28'($urandom) & ((28'd1 << w) - 28'd1);
        lb = 28'($urandom) & ((28'd1 << w) - 28'd1);
        if ($urandom_range(0, 7) != 0) la = la | msb;
        if ($urandom_range(0, 7) != 0) lb = lb | msb;
        a = a | (la << (l * w));
        b = b | (lb << (l * w));
      end
      v.a = a;
      v.b = b;
      v.lat = w + 1;
      model(v.op, v.a, v.b, v.q, v.s, v.d);
      run_vec(v, $sformatf("rand%0d", n));
    end

    // Back-pressure: result held in DONE; in_valid held high must not be taken early.
    start_op(2'b10, {4{7'h40}}, {4{7'h60}});
    wait_done(lat);
    q_hold = Q;
    chk("bp_first_Q", 64'(q_hold), 64'h55555555);
    in_valid = 1'b1;
    A = 28'h8000000;
    B = 28'h8000000;
    op = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_Q_stable", 64'(Q), 64'(q_hold));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_high", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);

    // Reset mid-division aborts immediately, then a fresh division completes.
    start_op(2'b00, 28'hC000000, 28'h8000000);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_Q", 64'(Q), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_vec(vecs[5], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
